// File: rtl/cl_dram_arb.sv
// Two-source DRAM master arbiter: s0 (host PCIS) and s1 (accelerator) share one
// AXI-style master port. Independent round-robin read and write arbiters; the
// downstream ID carries the source bit in its MSB for response routing.
module cl_dram_arb #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  // s0 slave
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [ADDR_W-1:0]     s0_awaddr,
  input  logic [ID_W-1:0]       s0_awid,
  input  logic [7:0]            s0_awlen,
  input  logic [2:0]            s0_awsize,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic [DATA_W/8-1:0]   s0_wstrb,
  input  logic                  s0_wlast,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  output logic [ID_W-1:0]       s0_bid,
  output logic [1:0]            s0_bresp,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_W-1:0]     s0_araddr,
  input  logic [ID_W-1:0]       s0_arid,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_W-1:0]     s0_rdata,
  output logic [ID_W-1:0]       s0_rid,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  // s1 slave
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [ADDR_W-1:0]     s1_awaddr,
  input  logic [ID_W-1:0]       s1_awid,
  input  logic [7:0]            s1_awlen,
  input  logic [2:0]            s1_awsize,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic [DATA_W/8-1:0]   s1_wstrb,
  input  logic                  s1_wlast,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  output logic [ID_W-1:0]       s1_bid,
  output logic [1:0]            s1_bresp,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_W-1:0]     s1_araddr,
  input  logic [ID_W-1:0]       s1_arid,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_W-1:0]     s1_rdata,
  output logic [ID_W-1:0]       s1_rid,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  // DRAM master
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [ID_W:0]         m_awid,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [ID_W:0]         m_bid,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [ID_W:0]         m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [ID_W:0]         m_rid,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast
);

  typedef enum logic {R_IDLE, R_REQ} r_state_t;
  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;
  logic     r_ptr, r_ptr_nxt, r_win, r_accept;
  logic     w_ptr, w_ptr_nxt, w_win, w_accept;
  logic     w_grant, w_grant_nxt;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;

  // Responses route on the source bit of the downstream ID
  assign s0_bvalid = m_bvalid & ~m_bid[ID_W];
  assign s1_bvalid = m_bvalid &  m_bid[ID_W];
  assign s0_bid    = m_bid[ID_W-1:0];
  assign s1_bid    = m_bid[ID_W-1:0];
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign m_bready  = m_bid[ID_W] ? s1_bready : s0_bready;

  assign s0_rvalid = m_rvalid & ~m_rid[ID_W];
  assign s1_rvalid = m_rvalid &  m_rid[ID_W];
  assign s0_rid    = m_rid[ID_W-1:0];
  assign s1_rid    = m_rid[ID_W-1:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = m_rid[ID_W] ? s1_rready : s0_rready;

  // Write data follows the latched grant
  assign m_wdata = w_grant ? s1_wdata : s0_wdata;
  assign m_wstrb = w_grant ? s1_wstrb : s0_wstrb;
  assign m_wlast = w_grant ? s1_wlast : s0_wlast;

  // Read FSM state and priority pointer
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_ptr   <= r_ptr_nxt;
    end
  end

  // Read arbitration: accept one AR in idle, then present it downstream
  always_comb begin
    r_state_nxt = r_state;
    r_ptr_nxt   = r_ptr;
    r_win       = (s0_arvalid & s1_arvalid) ? r_ptr : s1_arvalid;
    r_accept    = 1'b0;
    s0_arready  = 1'b0;
    s1_arready  = 1'b0;
    m_arvalid   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (!areset && (s0_arvalid || s1_arvalid)) begin
          r_accept    = 1'b1;
          s0_arready  = ~r_win;
          s1_arready  = r_win;
          r_ptr_nxt   = ~r_win;
          r_state_nxt = R_REQ;
        end
      end
      R_REQ: begin
        m_arvalid = ~areset;
        if (m_arready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Capture the winning AR payload
  always_ff @(posedge aclk) begin
    if (r_accept) begin
      m_araddr <= r_win ? s1_araddr : s0_araddr;
      m_arid   <= {r_win, (r_win ? s1_arid : s0_arid)};
      m_arlen  <= r_win ? s1_arlen : s0_arlen;
      m_arsize <= r_win ? s1_arsize : s0_arsize;
    end
  end

  // Write FSM state, pointer, grant and completion flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_ptr   <= 1'b0;
      w_grant <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      w_ptr   <= w_ptr_nxt;
      w_grant <= w_grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Write arbitration; W beats of the granted source flow while AW is pending
  always_comb begin
    w_state_nxt = w_state;
    w_ptr_nxt   = w_ptr;
    w_grant_nxt = w_grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    w_win       = (s0_awvalid & s1_awvalid) ? w_ptr : s1_awvalid;
    w_accept    = 1'b0;
    s0_awready  = 1'b0;
    s1_awready  = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    s0_wready   = 1'b0;
    s1_wready   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (!areset && (s0_awvalid || s1_awvalid)) begin
          w_accept    = 1'b1;
          s0_awready  = ~w_win;
          s1_awready  = w_win;
          w_ptr_nxt   = ~w_win;
          w_grant_nxt = w_win;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        m_awvalid = ~areset & ~aw_done;
        m_wvalid  = ~areset & ~w_done & (w_grant ? s1_wvalid : s0_wvalid);
        s0_wready = ~areset & ~w_done & ~w_grant & m_wready;
        s1_wready = ~areset & ~w_done &  w_grant & m_wready;
        if (m_awvalid && m_awready) aw_done_nxt = 1'b1;
        if (m_wvalid && m_wready && m_wlast) w_done_nxt = 1'b1;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Capture the winning AW payload
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      m_awaddr <= w_win ? s1_awaddr : s0_awaddr;
      m_awid   <= {w_win, (w_win ? s1_awid : s0_awid)};
      m_awlen  <= w_win ? s1_awlen : s0_awlen;
      m_awsize <= w_win ? s1_awsize : s0_awsize;
    end
  end

endmodule
